// File: rtl/nx_stream_scheduler_pkg.sv
// Shared node types: message layout, link direction and scheduler state encoding.
package NXConstants;

    localparam int MESSAGE_WIDTH = 32;

    typedef enum logic [1:0] {
        DIRECTION_NORTH = 2'd0,
        DIRECTION_EAST  = 2'd1,
        DIRECTION_SOUTH = 2'd2,
        DIRECTION_WEST  = 2'd3
    } direction_t;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [23:0] payload;
    } node_message_t;

    typedef enum logic {
        SCHED_IDLE  = 1'b0,
        SCHED_GRANT = 1'b1
    } sched_state_t;

endpackage

// File: rtl/nx_stream_scheduler_rr_picker.sv
// Rotating-priority first-one finder: searches upward from last_i+1 with wrap.
module nx_rr_picker #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  eligible_i,
    input  logic [IW-1:0] last_i,
    output logic          found_o,
    output logic [IW-1:0] index_o
);

    always_comb begin
        logic [IW-1:0] k;
        k       = '0;
        found_o = 1'b0;
        index_o = '0;
        for (int i = 1; i <= N; i++) begin
            k = IW'((int'(last_i) + i) % N);
            if (!found_o && eligible_i[k]) begin
                found_o = 1'b1;
                index_o = k;
            end
        end
    end

endmodule

// File: rtl/nx_stream_scheduler.sv
// Weighted round-robin scheduler merging STREAMS inbound message streams into one registered slot.
// Optional per-stream transfer counters are built when NX_STREAM_SCHED_STATS_EN is defined.
module nx_stream_scheduler
    import NXConstants::*;
#(
    parameter  int STREAMS      = 4,
    parameter  int WEIGHT_WIDTH = 4,
    localparam int GW           = $clog2(STREAMS)
) (
    input  logic                              clk_i,
    input  logic                              rstn_i,
    input  logic [STREAMS*WEIGHT_WIDTH-1:0]   weight_i,
    input  logic [STREAMS*MESSAGE_WIDTH-1:0]  req_data_i,
    input  logic [STREAMS*2-1:0]              req_dir_i,
    input  logic [STREAMS-1:0]                req_valid_i,
    output logic [STREAMS-1:0]                req_ready_o,
    output logic [MESSAGE_WIDTH-1:0]          sched_data_o,
    output logic [1:0]                        sched_dir_o,
    output logic                              sched_valid_o,
    input  logic                              sched_ready_i,
    output logic [GW-1:0]                     grant_o,
    output logic                              busy_o
`ifdef NX_STREAM_SCHED_STATS_EN
    ,
    output logic [STREAMS*16-1:0]             stats_o,
    input  logic                              stats_clear_i
`endif
);

    sched_state_t              state_q;
    logic [GW-1:0]             grant_q, last_q;
    logic [WEIGHT_WIDTH-1:0]   quota_q;
    node_message_t             data_q;
    direction_t                dir_q;
    logic                      valid_q;

    logic [STREAMS-1:0]        eligible;
    logic                      found;
    logic [GW-1:0]             pick;
    logic [WEIGHT_WIDTH-1:0]   pick_weight;
    logic                      can_accept, xfer;

    for (genvar k = 0; k < STREAMS; k++) begin : g_elig
        assign eligible[k] = req_valid_i[k] && (weight_i[k*WEIGHT_WIDTH +: WEIGHT_WIDTH] != '0);
    end

    nx_rr_picker #(.N(STREAMS)) u_picker (
        .eligible_i (eligible),
        .last_i     (last_q),
        .found_o    (found),
        .index_o    (pick)
    );

    assign pick_weight = weight_i[int'(pick)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign can_accept  = !valid_q || sched_ready_i;
    assign xfer        = (state_q == SCHED_GRANT) && can_accept && req_valid_i[grant_q];

    always_comb begin
        req_ready_o = '0;
        if (state_q == SCHED_GRANT && can_accept) req_ready_o[grant_q] = 1'b1;
    end

    // Quota only reloads in IDLE, so weight changes mid-burst wait for the next grant.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= SCHED_IDLE;
            grant_q <= '0;
            last_q  <= GW'(STREAMS - 1);
            quota_q <= '0;
        end else begin
            case (state_q)
                SCHED_IDLE: if (found) begin
                    state_q <= SCHED_GRANT;
                    grant_q <= pick;
                    last_q  <= pick;
                    quota_q <= pick_weight;
                end
                SCHED_GRANT: if (can_accept) begin
                    if (!req_valid_i[grant_q]) begin
                        state_q <= SCHED_IDLE;
                    end else begin
                        quota_q <= quota_q - WEIGHT_WIDTH'(1);
                        if (quota_q == WEIGHT_WIDTH'(1)) state_q <= SCHED_IDLE;
                    end
                end
                default: state_q <= SCHED_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            dir_q   <= DIRECTION_NORTH;
        end else if (xfer) begin
            valid_q <= 1'b1;
            data_q  <= node_message_t'(req_data_i[int'(grant_q)*MESSAGE_WIDTH +: MESSAGE_WIDTH]);
            dir_q   <= direction_t'(req_dir_i[int'(grant_q)*2 +: 2]);
        end else if (sched_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign sched_data_o  = data_q;
    assign sched_dir_o   = dir_q;
    assign sched_valid_o = valid_q;
    assign grant_o       = grant_q;
    assign busy_o        = (state_q == SCHED_GRANT);

`ifdef NX_STREAM_SCHED_STATS_EN
    for (genvar k = 0; k < STREAMS; k++) begin : g_stats
        logic [15:0] cnt_q;
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i)                                              cnt_q <= '0;
            else if (stats_clear_i)                                   cnt_q <= '0;
            else if (xfer && grant_q == GW'(k) && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        end
        assign stats_o[k*16 +: 16] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_nx_stream_scheduler.sv
// Bench for nx_stream_scheduler: directed timing scenarios plus randomized traffic vs. a burst-level WRR model.
module tb_nx_stream_scheduler;
    import NXConstants::*;

    localparam int N  = 4;
    localparam int WW = 4;
    localparam int MW = MESSAGE_WIDTH;
    localparam int GW = 2;

    logic              clk = 1'b0;
    logic              rstn;
    logic [N*WW-1:0]   weight;
    logic [N*MW-1:0]   req_data;
    logic [N*2-1:0]    req_dir;
    logic [N-1:0]      req_valid, req_ready;
    logic [MW-1:0]     sdata;
    logic [1:0]        sdir;
    logic              svalid, sready;
    logic [GW-1:0]     grant;
    logic              busy;
`ifdef NX_STREAM_SCHED_STATS_EN
    logic [N*16-1:0]   stats;
    logic              stats_clear = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int tw[N];
    int tlen[N];
    logic [MW+1:0] sq[N][$];
    logic [MW+1:0] expq[$];

    always #5 clk = ~clk;

    nx_stream_scheduler #(.STREAMS(N), .WEIGHT_WIDTH(WW)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .weight_i      (weight),
        .req_data_i    (req_data),
        .req_dir_i     (req_dir),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .sched_data_o  (sdata),
        .sched_dir_o   (sdir),
        .sched_valid_o (svalid),
        .sched_ready_i (sready),
        .grant_o       (grant),
        .busy_o        (busy)
`ifdef NX_STREAM_SCHED_STATS_EN
        ,
        .stats_o       (stats),
        .stats_clear_i (stats_clear)
`endif
    );

    task automatic set_w(input int w0, input int w1, input int w2, input int w3);
        tw[0] = w0; tw[1] = w1; tw[2] = w2; tw[3] = w3;
        for (int s = 0; s < N; s++) weight[s*WW +: WW] = WW'(tw[s]);
    endtask

    task automatic apply_reset();
        rstn = 1'b0; req_valid = '0; sready = 1'b1; req_data = '0; req_dir = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        set_w(1, 1, 1, 1);
        rstn = 1'b0; req_valid = '1; sready = 1'b1; req_data = '1; req_dir = '1;
        #1;
        checks++;
        if (svalid !== 1'b0 || sdata !== '0 || sdir !== 2'd0 || req_ready !== '0 || grant !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: valid=%b data=%h dir=%0d ready=%b grant=%0d busy=%b, want all zero", svalid, sdata, sdir, req_ready, grant, busy);
        end
        apply_reset();
    endtask

    task automatic test_latency();
        apply_reset(); set_w(1, 1, 1, 1);
        @(negedge clk); req_valid = 4'b0001; req_data[0 +: MW] = 32'hA5A5_0001; req_dir[1:0] = 2'd2; #1;
        checks++;
        if (busy !== 1'b0 || svalid !== 1'b0) begin errors++; $display("FAIL lat_c0: busy=%b valid=%b want 0 0", busy, svalid); end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b1 || grant !== 2'd0 || req_ready !== 4'b0001 || svalid !== 1'b0) begin
            errors++; $display("FAIL lat_c1: busy=%b grant=%0d ready=%b valid=%b want 1 0 0001 0", busy, grant, req_ready, svalid);
        end
        @(negedge clk); req_valid = '0; #1;
        checks++;
        if (svalid !== 1'b1 || sdata !== 32'hA5A5_0001 || sdir !== 2'd2 || busy !== 1'b0) begin
            errors++; $display("FAIL lat_c2: valid=%b data=%h dir=%0d busy=%b want 1 a5a50001 2 0", svalid, sdata, sdir, busy);
        end
        @(negedge clk); #1;
        checks++;
        if (svalid !== 1'b0) begin errors++; $display("FAIL lat_c3: valid=%b want 0", svalid); end
    endtask

    // Reference: bursts of min(weight, pending) messages, next stream found after the last granted one.
    task automatic run_traffic(input string name, input int stall_pct);
        int rem[N];
        int lst, found, n, k, cyc;
        logic prev_stall;
        logic [MW+1:0] prev_slot, tmp;
        apply_reset();
        for (int s = 0; s < N; s++) weight[s*WW +: WW] = WW'(tw[s]);
        expq.delete();
        for (int s = 0; s < N; s++) begin
            sq[s].delete();
            for (int i = 0; i < tlen[s]; i++) begin
                tmp = {2'($urandom_range(3)), 32'($urandom)};
                sq[s].push_back(tmp);
            end
            rem[s] = tlen[s];
        end
        lst = N - 1;
        forever begin
            found = -1;
            for (int i = 1; i <= N; i++) begin
                k = (lst + i) % N;
                if (found < 0 && rem[k] > 0 && tw[k] > 0) found = k;
            end
            if (found < 0) break;
            n = (tw[found] < rem[found]) ? tw[found] : rem[found];
            for (int j = 0; j < n; j++) expq.push_back(sq[found][tlen[found] - rem[found] + j]);
            rem[found] -= n;
            lst = found;
        end
        cyc = 0; prev_stall = 1'b0; prev_slot = '0;
        while (expq.size() > 0 && cyc < 3000) begin
            @(negedge clk);
            for (int s = 0; s < N; s++) begin
                req_valid[s] = (sq[s].size() > 0);
                if (sq[s].size() > 0) {req_dir[s*2 +: 2], req_data[s*MW +: MW]} = sq[s][0];
            end
            sready = ($urandom_range(99) >= stall_pct);
            #1;
            if (prev_stall) begin
                checks++;
                if ({sdir, sdata} !== prev_slot) begin errors++; $display("FAIL %s stall_hold: got %h want %h", name, {sdir, sdata}, prev_slot); end
            end
            for (int s = 0; s < N; s++) begin
                if (tw[s] == 0) begin
                    checks++;
                    if (req_ready[s] !== 1'b0) begin errors++; $display("FAIL %s zero_weight_ready[%0d]: got %b want 0", name, s, req_ready[s]); end
                end else if (req_ready[s] === 1'b1) begin
                    checks++;
                    if (busy !== 1'b1 || grant !== GW'(s)) begin errors++; $display("FAIL %s ready_owner[%0d]: busy=%b grant=%0d", name, s, busy, grant); end
                end
            end
            if (svalid === 1'b1 && sready) begin
                checks++;
                if ({sdir, sdata} !== expq[0]) begin errors++; $display("FAIL %s order: got %h want %h", name, {sdir, sdata}, expq[0]); end
                void'(expq.pop_front());
            end
            prev_stall = (svalid === 1'b1) && !sready;
            prev_slot  = {sdir, sdata};
            for (int s = 0; s < N; s++) if (req_valid[s] && req_ready[s]) void'(sq[s].pop_front());
            cyc++;
        end
        checks++;
        if (expq.size() != 0) begin errors++; $display("FAIL %s timeout: %0d outputs missing, want 0", name, expq.size()); end
        for (int s = 0; s < N; s++) if (tw[s] == 0) begin
            checks++;
            if (sq[s].size() != tlen[s]) begin errors++; $display("FAIL %s zero_weight_drain[%0d]: left %0d want %0d", name, s, sq[s].size(), tlen[s]); end
        end
        @(negedge clk); req_valid = '0; sready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_round_robin();
        set_w(1, 1, 1, 1);
        for (int s = 0; s < N; s++) tlen[s] = 4;
        run_traffic("rr_equal", 0);
    endtask

    task automatic test_weighted();
        set_w(1, 3, 1, 1);
        tlen[0] = 6; tlen[1] = 18; tlen[2] = 6; tlen[3] = 6;
        run_traffic("wrr_1311", 0);
    endtask

    task automatic test_weight_zero();
        set_w(0, 2, 2, 3);
        tlen[0] = 5; tlen[1] = 0; tlen[2] = 0; tlen[3] = 40;
        run_traffic("weight_zero", 25);
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            set_w($urandom_range(15), $urandom_range(15), $urandom_range(15), $urandom_range(15));
            for (int s = 0; s < N; s++) tlen[s] = $urandom_range(20);
            run_traffic("random", 30);
        end
    endtask

    task automatic test_early_release();
        apply_reset(); set_w(1, 1, 4, 1);
        @(negedge clk); req_valid = 4'b0100; req_data[2*MW +: MW] = 32'h0000_2000; #1;
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b1 || grant !== 2'd2 || req_ready !== 4'b0100) begin errors++; $display("FAIL early_grant: busy=%b grant=%0d ready=%b", busy, grant, req_ready); end
        @(negedge clk); req_data[2*MW +: MW] = 32'h0000_2001; #1;
        checks++;
        if (req_ready !== 4'b0100 || svalid !== 1'b1 || sdata !== 32'h0000_2000) begin errors++; $display("FAIL early_beat0: ready=%b valid=%b data=%h", req_ready, svalid, sdata); end
        @(negedge clk); req_valid = '0; #1;
        checks++;
        if (busy !== 1'b1 || svalid !== 1'b1 || sdata !== 32'h0000_2001) begin errors++; $display("FAIL early_beat1: busy=%b valid=%b data=%h want 1 1 00002001", busy, svalid, sdata); end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || svalid !== 1'b0) begin errors++; $display("FAIL early_release: busy=%b valid=%b want 0 0", busy, svalid); end
    endtask

    task automatic test_backpressure();
        logic [MW-1:0] d[4];
        for (int i = 0; i < 4; i++) d[i] = 32'hB000_0000 + MW'(i);
        apply_reset(); set_w(1, 3, 1, 1);
        @(negedge clk); req_valid = 4'b0010; req_data[MW +: MW] = d[0]; #1;
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b1 || grant !== 2'd1 || req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: busy=%b grant=%0d ready=%b", busy, grant, req_ready); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); req_data[MW +: MW] = d[1]; sready = 1'b0; #1;
            checks++;
            if (svalid !== 1'b1 || sdata !== d[0] || req_ready !== 4'b0000 || busy !== 1'b1) begin
                errors++; $display("FAIL bp_stall%0d: valid=%b data=%h ready=%b busy=%b", c, svalid, sdata, req_ready, busy);
            end
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); sready = 1'b1; req_data[MW +: MW] = d[c+1]; #1;
            checks++;
            if (sdata !== d[c] || req_ready !== 4'b0010) begin errors++; $display("FAIL bp_resume%0d: data=%h ready=%b want %h 0010", c, sdata, req_ready, d[c]); end
        end
        @(negedge clk); req_data[MW +: MW] = d[3]; #1;
        checks++;
        if (sdata !== d[2] || svalid !== 1'b1 || busy !== 1'b0 || req_ready !== '0) begin
            errors++; $display("FAIL bp_quota_end: data=%h valid=%b busy=%b ready=%b want %h 1 0 0000", sdata, svalid, busy, req_ready, d[2]);
        end
        @(negedge clk); req_valid = '0;
    endtask

    task automatic test_all_zero();
        apply_reset(); set_w(0, 0, 0, 0);
        req_valid = '1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            checks++;
            if (req_ready !== '0 || busy !== 1'b0 || svalid !== 1'b0) begin errors++; $display("FAIL all_zero%0d: ready=%b busy=%b valid=%b", c, req_ready, busy, svalid); end
        end
        req_valid = '0;
    endtask

    task automatic test_reset_midburst();
        apply_reset(); set_w(2, 5, 1, 1);
        @(negedge clk); req_valid = 4'b0010; req_data[MW +: MW] = 32'hC0DE_0001;
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if (busy !== 1'b1 || grant !== 2'd1 || svalid !== 1'b1) begin errors++; $display("FAIL mid_burst_setup: busy=%b grant=%0d valid=%b", busy, grant, svalid); end
        @(negedge clk); rstn = 1'b0; req_valid = 4'b0011; #1;
        checks++;
        if (svalid !== 1'b0 || sdata !== '0 || sdir !== 2'd0 || busy !== 1'b0 || grant !== '0 || req_ready !== '0) begin
            errors++; $display("FAIL mid_reset: valid=%b data=%h dir=%0d busy=%b grant=%0d ready=%b", svalid, sdata, sdir, busy, grant, req_ready);
        end
`ifdef NX_STREAM_SCHED_STATS_EN
        checks++;
        if (stats !== '0) begin errors++; $display("FAIL mid_reset_stats: got %h want 0", stats); end
`endif
        @(negedge clk); rstn = 1'b1; #1;
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b1 || grant !== 2'd0) begin errors++; $display("FAIL post_reset_grant: busy=%b grant=%0d want 1 0", busy, grant); end
        @(negedge clk); req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_round_robin();
        test_weighted();
        test_early_release();
        test_backpressure();
        test_weight_zero();
        test_random();
        test_all_zero();
        test_reset_midburst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nx_stream_scheduler.md
Name: nx_stream_scheduler

Overview:
- Weighted round-robin scheduler sharing one outbound node message stream between STREAMS requesters (node core, decoder loopback, bypass paths).
- Generalises two-way combining to N inputs with per-requester burst quotas, so a busy source cannot starve the rest.
- Output is a single registered slot with valid/ready; it feeds the node's outbound distributor.

Parameters:
- STREAMS, 4, number of inbound requesters (2..8).
- WEIGHT_WIDTH, 4, width of each per-stream quota (maximum burst = 2^WEIGHT_WIDTH-1 messages).

Ports:
- clk_i  input  1  clock.
- rstn_i  input  1  asynchronous, active-low reset.
- weight_i  input  STREAMS*WEIGHT_WIDTH  per-stream quota; stream k occupies bits [k*WEIGHT_WIDTH +: WEIGHT_WIDTH]; value 0 disables stream k.
- req_data_i  input  STREAMS*MESSAGE_WIDTH  inbound messages, packed as node_message_t per stream.
- req_dir_i  input  STREAMS*2  inbound direction_t per stream.
- req_valid_i  input  STREAMS  inbound valid.
- req_ready_o  output  STREAMS  inbound ready.
- sched_data_o  output  MESSAGE_WIDTH  outbound node_message_t.
- sched_dir_o  output  2  outbound direction_t.
- sched_valid_o  output  1  outbound valid.
- sched_ready_i  input  1  outbound ready.
- grant_o  output  $clog2(STREAMS)  index of the currently granted stream.
- busy_o  output  1  high while a grant is held (state GRANT).

Behaviour:
- Reset values (asynchronous, rstn_i low):
  - sched_valid_o=0, sched_data_o=0, sched_dir_o=DIRECTION_NORTH.
  - req_ready_o=0, grant_o=0, busy_o=0.
  - state=IDLE, quota counter=0.
  - Rotation pointer last=STREAMS-1, so stream 0 has first priority.
- Output slot: loads when a transfer occurs (req_valid_i[g] && req_ready_o[g]).
  - Otherwise it clears when sched_ready_i is high.
  - Otherwise it holds; data and dir are stable while valid && !ready.
- req_ready_o[k] = (state==GRANT) && (k==grant) && (!sched_valid_o || sched_ready_i). All non-granted readies are 0.
- Eligible streams: req_valid_i[k] && weight_i[k]!=0.
- IDLE state:
  - Search from (last+1) mod STREAMS, upward with wrap, for the first eligible stream.
  - If one is found: register grant=k, load quota=weight_i[k] (sampled only here), set last=k, go to GRANT.
  - If none is found: stay in IDLE.
- GRANT state:
  - Each transfer decrements quota.
  - Return to IDLE when the transfer drops quota to 0.
  - Also return to IDLE when req_valid_i[grant]=0 in a cycle where the slot could accept (early release).
  - A downstream stall (slot full and !sched_ready_i) holds state and quota indefinitely.
- Latency:
  - A request arriving in IDLE at cycle N is granted at edge N+1 and transferred during cycle N+1.
  - sched_valid_o is high in cycle N+2.
  - Within a burst, throughput is 1 message/cycle.
  - Each grant switch costs exactly one IDLE bubble cycle.
- Weight changes while in GRANT have no effect until the next IDLE sample.
- Reset asserted mid-burst discards the slot contents and the grant; no partial state survives.
- All weights 0: the block never grants and all req_ready_o stay 0.
- Quota counter is WEIGHT_WIDTH bits wide; it cannot underflow because it is loaded non-zero.

Optional Feature:
- Macro: NX_STREAM_SCHED_STATS_EN.
- Defined:
  - Adds output stats_o, STREAMS*16 bits, one per-stream saturating count of transferred messages.
  - Counts saturate at 16'hFFFF and reset to 0.
  - Adds input stats_clear_i, 1 bit: a synchronous clear that takes priority over a same-cycle increment.
- Undefined: neither port exists and no counter logic is generated. Scheduling behaviour is identical either way.

Decomposition:
- NXConstants supplies node_message_t, direction_t and MESSAGE_WIDTH.
- Add sched_state_t (SCHED_IDLE, SCHED_GRANT) to NXConstants.
- Sub-module nx_rr_picker: combinational rotating-priority first-one finder.
  - Inputs: eligible mask, last pointer. Outputs: found, index.
  - It is reusable by other arbiters.

Test Plan:
- Reset with STREAMS=4, all weights=1, all valid, sched_ready_i=1: grants follow 0,1,2,3,0,…, one message every 2 cycles, valid first high 2 cycles after release.
- Weights {1,3,1,1} (stream0..3), all valid continuously: output source sequence is 0,1,1,1,2,3 repeating, with one bubble per switch.
- Stream 2 only, weight 4, holding valid 2 messages then dropping: 2 transfers, early release to IDLE, busy_o falls the cycle after valid drops.
- Stream 1 granted, quota 3, sched_ready_i held low 10 cycles after first transfer: sched_data_o stable, req_ready_o[1]=0, quota still 2; on release the burst completes with 2 more transfers.
- weight_i[0]=0 with stream 0 valid and stream 3 valid: only stream 3 is granted; req_ready_o[0] stays 0 for 50 cycles.
- rstn_i pulsed low during a stream 1 burst: outputs immediately reach reset values; after release the first grant goes to stream 0 if valid. With NX_STREAM_SCHED_STATS_EN, counters read 0.
